// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// State codes, opcodes, ALU selector codes and the overflow code.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CAPT = 2'b10,
    S_RESP = 2'b11
  } state_t;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NOT   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MULT  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  localparam logic [1:0] ALU_OVF = 2'b11;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to one-hot ALU out_selector decoder.
// CLEAR has no selector; it only raises is_clear.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic [6:0] out_sel,
  output logic       is_clear
);

  // one-hot selector per opcode
  always_comb begin
    out_sel  = 7'b0000000;
    is_clear = 1'b0;
    case (op)
      OP_AND:   out_sel = 7'b1000000;
      OP_OR:    out_sel = 7'b0100000;
      OP_NOT:   out_sel = 7'b0010000;
      OP_XOR:   out_sel = 7'b0001000;
      OP_ADD:   out_sel = 7'b0000100;
      OP_SUB:   out_sel = 7'b0000010;
      OP_MULT:  out_sel = 7'b0000001;
      default:  is_clear = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end that loads operands into the ALU, samples its result
// and returns it over a valid/ready handshake with a shadow acc.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_chain,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         alu_on,
  output logic [2:0]   alu_in_sel,
  output logic [W-1:0] alu_num1,
  output logic [W-1:0] alu_num2,
  output logic [6:0]   alu_out_sel,
  input  logic [W-1:0] alu_result,
  input  logic [1:0]   alu_state
);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] acc;
  logic         clr_q;
  logic [6:0]   dec_sel;
  logic         dec_clr;
  logic         accept;

  alu_op_decode u_dec (
    .op       (cmd_op),
    .out_sel  (dec_sel),
    .is_clear (dec_clr)
  );

  assign cmd_ready = (state_q == S_IDLE) && alu_on;
  assign rsp_valid = (state_q == S_RESP);
  assign accept    = cmd_valid && cmd_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state: one pass IDLE->LOAD->CAPT->RESP per command
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = S_CAPT;
      S_CAPT: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drives: RESET only for the CLEAR cycle, else LOAD with held operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_on      <= 1'b0;
      alu_in_sel  <= SEL_RESET;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= 7'b1000000;
      clr_q       <= 1'b0;
    end else begin
      alu_on     <= 1'b1;
      alu_in_sel <= (accept && dec_clr) ? SEL_RESET : SEL_LOAD;
      if (accept) begin
        clr_q <= dec_clr;
        if (!dec_clr) begin
          alu_num1    <= cmd_chain ? acc : cmd_a;
          alu_num2    <= cmd_b;
          alu_out_sel <= dec_sel;
        end
      end
    end
  end

  // result capture and shadow accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept && dec_clr) begin
      acc <= '0;
    end else if (state_q == S_CAPT) begin
      rsp_data <= clr_q ? '0 : alu_result;
      acc      <= clr_q ? '0 : alu_result;
      rsp_err  <= !clr_q && (alu_state == ALU_OVF);
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end that sits directly upstream of the 8-bit ALU datapath (`main`) and drives its `on`, `in_selector`, `num1`, `num2` and `out_selector` inputs. It accepts one operation at a time over a valid/ready handshake, loads the operands into the ALU, samples `outputVal` and the ALU's `state` output, and returns result plus overflow error over a second valid/ready handshake. It also keeps a shadow accumulator so chained operations reuse the previous result.

## Interface
- `W`, default 8: operand/result width; must match the ALU.
- `clk`  in  1  rising-edge clock shared with the ALU.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR.
- `cmd_chain`  in  1  1: operand A is the shadow accumulator; `cmd_a` is ignored.
- `cmd_a`, `cmd_b`  in  W  operands.
- `rsp_valid`  out  1  result held.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  W  result.
- `rsp_err`  out  1  overflow reported by the ALU.
- `alu_on`, `alu_in_sel[2:0]`, `alu_num1[W]`, `alu_num2[W]`, `alu_out_sel[6:0]`  out  drive the ALU inputs of the same names. All are registered.
- `alu_result`  in  W  ALU `outputVal`.
- `alu_state`  in  2  ALU `state`. `2'b11` means overflow.

## Operation
- FSM states: IDLE, LOAD, CAPT, RESP.
  - IDLE: `cmd_ready = alu_on`. On handshake, go to LOAD and register the ALU drives:
    - `alu_in_sel` = 3'b010 (load).
    - `alu_num1` = `cmd_chain` ? acc : `cmd_a`.
    - `alu_num2` = `cmd_b`.
    - `alu_out_sel` is one-hot: AND 7'b1000000, OR 0100000, NOT 0010000, XOR 0001000, ADD 0000100, SUB 0000010, MULT 0000001.
  - CLEAR in IDLE: drive `alu_in_sel` = 3'b001 for one cycle, set acc := 0, go to LOAD. The result is forced to 0 with err 0.
  - LOAD: the ALU input DFFs capture at the end of this cycle. Go to CAPT.
  - CAPT: on this edge, sample `alu_result` into `rsp_data` and acc, and set `rsp_err = (alu_state == 2'b11)` (0 for CLEAR). Go to RESP. `alu_in_sel` returns to 3'b010 with operands held.
  - RESP: `rsp_valid` = 1, and `rsp_data`/`rsp_err` are stable. When `rsp_ready`, return to IDLE the same edge.
- Persist (3'b100) is never driven. The ALU would recirculate `outputVal` every cycle; chaining uses acc instead.
- Outside the CLEAR cycle, `alu_in_sel` is always 3'b010 with the last operands held. The ALU output is therefore stable while idle.
- A NOT result depends on A only; `cmd_b` is still loaded.
- Arithmetic is performed entirely by the ALU. The sequencer does no width extension: results are W bits, and carry/borrow are dropped.

## Timing
- Reset values (asynchronous): FSM IDLE, `alu_on` 0, `alu_in_sel` 3'b001, `alu_num1`/`alu_num2` 0, `alu_out_sel` 7'b1000000, acc 0, `cmd_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0.
- `alu_on` rises on the first clock edge after `rst` deasserts. The first command can be accepted the cycle after that.
- Latency: accept at edge E0. `rsp_valid` is high after E2. The earliest next accept is the edge after the `rsp_ready` handshake, giving a 4-cycle minimum throughput.
- `cmd_ready` is low in LOAD, CAPT and RESP. `cmd_valid` in those states is ignored and must be held by the producer.
- If `rsp_ready` is held high in RESP, RESP lasts exactly one cycle.
- Reset mid-operation: abort immediately to reset values. Any in-flight result is discarded and `rsp_valid` drops asynchronously.

## Structure
- Package `alu_seq_pkg`:
  - State encoding, 2-bit: IDLE 00, LOAD 01, CAPT 10, RESP 11.
  - Opcode constants.
  - `in_selector` constants: PERSIST 3'b100, LOAD 3'b010, RESET 3'b001.
  - ALU overflow state code 2'b11.
- Sub-module `alu_op_decode`: combinational, 3-bit opcode to 7-bit one-hot `out_selector` plus an `is_clear` flag.

## Test plan
- Reset release: all outputs at reset values; `alu_on` = 1 one edge later, then `cmd_ready` = 1.
- ADD a=8'h12, b=8'h34: `alu_out_sel` = 0000100 and `alu_num1`/`alu_num2` = 12/34 in LOAD; `rsp_data` = 8'h46, `rsp_err` = 0, `rsp_valid` after exactly 2 edges.
- Chained SUB with b=8'h06 after the previous test: `alu_num1` = 8'h46; `rsp_data` = 8'h40.
- MULT a=8'h20, b=8'h10 with the ALU model reporting `alu_state` = 2'b11 at CAPT: `rsp_err` = 1.
- CLEAR: `alu_in_sel` = 3'b001 for one cycle; `rsp_data` = 0; a following chained OR with b=8'h0F returns 8'h0F.
- Backpressure: `rsp_ready` low for 5 cycles means data stays stable and `cmd_ready` stays 0. Asserting `rst` during CAPT means `rsp_valid` never rises and acc = 0.
